// File: rtl/instruction_fetch.sv
// PC and instruction-fetch stage: holds the PC and fetches 16-bit words over a req/ack handshake.
// Optional breakpoint logic is enabled with `define BREAKPOINT_EN.
module instruction_fetch #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pc_increment,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       current_instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] program_counter,
    output logic              fetch_error
`ifdef BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_enable,
    input  logic              bp_resume,
    output logic              bp_hit
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0] HALT  = 16'h0300;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY, S_ERROR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                req_q, req_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
`ifdef BREAKPOINT_EN
    logic [15:0]         shadow_q, shadow_d;
    logic                hit_q, hit_d;
    logic                armed_q, armed_d;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        req_d       = req_q;
        err_d       = err_q;
        wait_d      = wait_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
`ifdef BREAKPOINT_EN
        shadow_d    = shadow_q;
        hit_d       = hit_q;
        armed_d     = armed_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                wait_d  = '0;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    // A redirect seen during this fetch discards the returned word and refetches.
                    if (pend_q || pc_load) begin
                        pc_d   = pc_load ? pc_load_value : pend_addr_q;
                        pend_d = 1'b0;
                        wait_d = '0;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_READY;
`ifdef BREAKPOINT_EN
                        if (bp_enable && armed_q && (pc_q == bp_addr)) begin
                            instr_d  = HALT;
                            shadow_d = imem_rdata;
                            hit_d    = 1'b1;
                            armed_d  = 1'b0;
                        end
`endif
                    end
                end else begin
                    if (pc_load) begin
                        pend_d      = 1'b1;
                        pend_addr_d = pc_load_value;
                    end
                    if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                        instr_d = HALT;
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        pend_d  = 1'b0;
                        state_d = S_ERROR;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
            end
            S_READY: begin
`ifdef BREAKPOINT_EN
                if (hit_q && bp_resume) begin
                    instr_d = shadow_q;
                    hit_d   = 1'b0;
                end
`endif
                if (pc_load || pc_increment) begin
                    pc_d    = pc_load ? pc_load_value : pc_q + ADDR_W'(1);
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
`ifdef BREAKPOINT_EN
        if (pc_d != pc_q) armed_d = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            instr_q     <= HALT;
            valid_q     <= 1'b0;
            req_q       <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
`ifdef BREAKPOINT_EN
            shadow_q    <= HALT;
            hit_q       <= 1'b0;
            armed_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            req_q       <= req_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
`ifdef BREAKPOINT_EN
            shadow_q    <= shadow_d;
            hit_q       <= hit_d;
            armed_q     <= armed_d;
`endif
        end
    end

    assign imem_req            = req_q;
    assign imem_addr           = pc_q;
    assign current_instruction = instr_q;
    assign instr_valid         = valid_q;
    assign program_counter     = pc_q;
    assign fetch_error         = err_q;
`ifdef BREAKPOINT_EN
    assign bp_hit              = hit_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory returns 16'h1234 + {addr,addr} after a set delay.
module tb_instruction_fetch;

    logic        clock;
    logic        resetn;
    logic        pc_increment;
    logic        pc_load;
    logic [7:0]  pc_load_value;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] current_instruction;
    logic        instr_valid;
    logic [7:0]  program_counter;
    logic        fetch_error;
`ifdef BREAKPOINT_EN
    logic [7:0]  bp_addr;
    logic        bp_enable;
    logic        bp_resume;
    logic        bp_hit;
`endif

    int n_chk = 0;
    int n_err = 0;
    int ack_dly = 1;
    bit ack_en = 1'b1;
    int n_acks = 0;
    int acks_before;

    instruction_fetch dut (
        .clock(clock),
        .resetn(resetn),
        .pc_increment(pc_increment),
        .pc_load(pc_load),
        .pc_load_value(pc_load_value),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .current_instruction(current_instruction),
        .instr_valid(instr_valid),
        .program_counter(program_counter),
        .fetch_error(fetch_error)
`ifdef BREAKPOINT_EN
        ,
        .bp_addr(bp_addr),
        .bp_enable(bp_enable),
        .bp_resume(bp_resume),
        .bp_hit(bp_hit)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after ack_dly cycles of a steady request.
    initial begin
        int cnt;
        logic [7:0] last_addr;
        cnt = 0;
        last_addr = 8'h00;
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(posedge clock);
            #1;
            if (imem_req) begin
                if (imem_addr != last_addr) cnt = 0;
                if (ack_en && cnt >= ack_dly) begin
                    imem_ack = 1'b1;
                    imem_rdata = 16'h1234 + {imem_addr, imem_addr};
                    cnt = 0;
                    n_acks++;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                cnt = 0;
            end
            last_addr = imem_addr;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_ready(input int max);
        int k;
        k = 0;
        while (!instr_valid && k < max) begin
            step();
            k++;
        end
        if (!instr_valid) chk("ready_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic go_load(input logic [7:0] a);
        pc_load = 1'b1;
        pc_load_value = a;
        step();
        pc_load = 1'b0;
    endtask

    task automatic go_inc();
        pc_increment = 1'b1;
        step();
        pc_increment = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        pc_increment = 1'b0;
        pc_load = 1'b0;
        pc_load_value = 8'h00;
`ifdef BREAKPOINT_EN
        bp_addr = 8'h00;
        bp_enable = 1'b0;
        bp_resume = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(current_instruction), 32'h0300);
        chk("rst_err", 32'(fetch_error), 32'd0);
        chk("rst_pc", 32'(program_counter), 32'h00);

        // 1: first fetch from address 0, ack one cycle after request
        resetn = 1'b1;
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", 32'(imem_addr), 32'h00);
        chk("t1_valid0", 32'(instr_valid), 32'd0);
        step();
        chk("t1_valid1", 32'(instr_valid), 32'd0);
        step();
        chk("t1_valid2", 32'(instr_valid), 32'd1);
        chk("t1_instr", 32'(current_instruction), 32'h1234);
        chk("t1_req_drop", 32'(imem_req), 32'd0);

        // 2: increment from pc=5
        go_load(8'h05);
        wait_ready(20);
        chk("t2_pc5", 32'(program_counter), 32'h05);
        chk("t2_instr5", 32'(current_instruction), 32'h1739);
        go_inc();
        chk("t2_addr", 32'(imem_addr), 32'h06);
        chk("t2_req", 32'(imem_req), 32'd1);
        chk("t2_valid_lo", 32'(instr_valid), 32'd0);
        step();
        chk("t2_valid_lo2", 32'(instr_valid), 32'd0);
        step();
        chk("t2_valid_hi", 32'(instr_valid), 32'd1);
        chk("t2_instr6", 32'(current_instruction), 32'h183A);

        // 3: load and increment together, load wins, single fetch
        acks_before = n_acks;
        pc_load = 1'b1;
        pc_load_value = 8'h40;
        pc_increment = 1'b1;
        step();
        pc_load = 1'b0;
        pc_increment = 1'b0;
        chk("t3_addr", 32'(imem_addr), 32'h40);
        wait_ready(20);
        repeat (3) step();
        chk("t3_pc", 32'(program_counter), 32'h40);
        chk("t3_instr", 32'(current_instruction), 32'h5274);
        chk("t3_one_fetch", 32'(n_acks - acks_before), 32'd1);
        chk("t3_hold_req", 32'(imem_req), 32'd0);

        // 4a: wrap from 0xFF
        go_load(8'hFF);
        wait_ready(20);
        chk("t4_instr_ff", 32'(current_instruction), 32'h1233);
        go_inc();
        chk("t4_wrap_addr", 32'(imem_addr), 32'h00);
        wait_ready(20);
        chk("t4_wrap_instr", 32'(current_instruction), 32'h1234);
        chk("t4_wrap_err", 32'(fetch_error), 32'd0);

        // 4b: redirects during an outstanding fetch of 0x20; last target wins
        ack_dly = 4;
        go_load(8'h20);
        chk("t4_fetch20", 32'(imem_addr), 32'h20);
        pc_load = 1'b1;
        pc_load_value = 8'h30;
        step();
        pc_load_value = 8'h10;
        pc_increment = 1'b1;
        step();
        pc_load = 1'b0;
        pc_increment = 1'b0;
        chk("t4_hold20", 32'(imem_addr), 32'h20);
        chk("t4_hold_req", 32'(imem_req), 32'd1);
        begin
            int k;
            k = 0;
            while (imem_addr != 8'h10 && k < 20) begin
                step();
                k++;
            end
        end
        chk("t4_redirect", 32'(imem_addr), 32'h10);
        chk("t4_not_valid", 32'(instr_valid), 32'd0);
        wait_ready(20);
        chk("t4_pc10", 32'(program_counter), 32'h10);
        chk("t4_instr10", 32'(current_instruction), 32'h2244);

        // 5: ack never arrives
        ack_dly = 1;
        ack_en = 1'b0;
        go_load(8'h55);
        chk("t5_req", 32'(imem_req), 32'd1);
        repeat (14) step();
        chk("t5_req_14", 32'(imem_req), 32'd1);
        chk("t5_err_14", 32'(fetch_error), 32'd0);
        step();
        chk("t5_err", 32'(fetch_error), 32'd1);
        chk("t5_req_lo", 32'(imem_req), 32'd0);
        chk("t5_halt", 32'(current_instruction), 32'h0300);
        ack_en = 1'b1;
        pc_increment = 1'b1;
        pc_load = 1'b1;
        pc_load_value = 8'h77;
        repeat (5) step();
        pc_increment = 1'b0;
        pc_load = 1'b0;
        chk("t5_frozen_err", 32'(fetch_error), 32'd1);
        chk("t5_frozen_req", 32'(imem_req), 32'd0);
        chk("t5_frozen_pc", 32'(program_counter), 32'h55);
        chk("t5_frozen_ins", 32'(current_instruction), 32'h0300);
        resetn = 1'b0;
        #1;
        chk("t5_rst_err", 32'(fetch_error), 32'd0);
        chk("t5_rst_pc", 32'(program_counter), 32'h00);

        // Reset asserted mid-fetch drops the request without a clock edge
        ack_en = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("mid_req", 32'(imem_req), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_req_drop", 32'(imem_req), 32'd0);
        step();
        ack_en = 1'b1;
        resetn = 1'b1;
        wait_ready(20);
        chk("mid_refetch", 32'(current_instruction), 32'h1234);

`ifdef BREAKPOINT_EN
        // 6: breakpoint at address 3
        resetn = 1'b0;
        bp_addr = 8'h03;
        bp_enable = 1'b1;
        step();
        chk("t6_rst_hit", 32'(bp_hit), 32'd0);
        resetn = 1'b1;
        step();
        wait_ready(20);
        chk("t6_pc0_hit", 32'(bp_hit), 32'd0);
        go_inc();
        wait_ready(20);
        go_inc();
        wait_ready(20);
        chk("t6_pc2_instr", 32'(current_instruction), 32'h1436);
        go_inc();
        wait_ready(20);
        chk("t6_pc3", 32'(program_counter), 32'h03);
        chk("t6_halt", 32'(current_instruction), 32'h0300);
        chk("t6_hit", 32'(bp_hit), 32'd1);
        step();
        chk("t6_hit_sticky", 32'(bp_hit), 32'd1);
        bp_resume = 1'b1;
        step();
        bp_resume = 1'b0;
        chk("t6_resume_ins", 32'(current_instruction), 32'h1537);
        chk("t6_resume_hit", 32'(bp_hit), 32'd0);
        go_inc();
        wait_ready(20);
        chk("t6_pc4_instr", 32'(current_instruction), 32'h1638);
        chk("t6_pc4_hit", 32'(bp_hit), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
